// File: rtl/dmem_responder_pkg.sv
// Shared processor-side definitions for the data-memory responder: state and op
// encodings, default sizing constants and the address legality check.
package dmem_responder_pkg;

    localparam int DATA_W         = 16;
    localparam int ADDR_W         = 16;
    localparam int LATENCY_DEF    = 2;
    localparam int DEPTH_LOG2_DEF = 8;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Word-aligned and inside the 2**depth_log2 word window.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a, input int depth_log2);
        logic [ADDR_W-1:0] hi_mask;
        hi_mask = {ADDR_W{1'b1}} << (depth_log2 + 1);
        return (a[0] == 1'b0) && ((a & hi_mask) == '0);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] writeData;
    logic              memRead;
    logic              memWrite;
    logic              halt;
    logic [DATA_W-1:0] readData;
    logic              done;
    logic              stall;
    logic              err;

    modport master (
        output addr, writeData, memRead, memWrite, halt,
        input  readData, done, stall, err
    );

    modport slave (
        input  addr, writeData, memRead, memWrite, halt,
        output readData, done, stall, err
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage for the responder: one synchronous write port, one asynchronous
// read port. Contents are deliberately never reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: accepts one load/store in IDLE, completes it LATENCY
// cycles later with a done pulse, flags illegal requests, and parks on halt.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LATENCY    = LATENCY_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    op_t                   op_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  halt_pend;
    logic [DATA_W-1:0]     read_data_q;
    logic                  done_q;
    logic                  stall_q;
    logic                  err_q;

    logic                  fire;
    logic                  mem_we;
    logic                  req_both;
    logic                  req_one;
    logic                  req_legal;
    logic [DATA_W-1:0]     rd_word;

    assign fire      = (state == ST_BUSY) && (cnt == '0);
    // Gating with rst keeps a reset edge from committing an in-flight store.
    assign mem_we    = fire && (op_q == OP_WRITE) && rst;
    assign req_both  = bus.memRead && bus.memWrite;
    assign req_one   = bus.memRead ^ bus.memWrite;
    assign req_legal = addr_legal(bus.addr, DEPTH_LOG2);

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (idx_q),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            halt_pend   <= 1'b0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            stall_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    halt_pend <= 1'b0;
                    if (bus.halt) begin
                        state   <= ST_HALTED;
                        stall_q <= 1'b0;
                    end else if (req_both || ((bus.memRead || bus.memWrite) && !req_legal)) begin
                        err_q <= 1'b1;
                    end else if (req_one) begin
                        op_q    <= bus.memWrite ? OP_WRITE : OP_READ;
                        idx_q   <= bus.addr[DEPTH_LOG2:1];
                        wdata_q <= bus.writeData;
                        cnt     <= CNT_LOAD;
                        state   <= ST_BUSY;
                        stall_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    // A halt seen at any point of the access is honoured once it completes.
                    if (bus.halt) begin
                        halt_pend <= 1'b1;
                    end
                    if (cnt == '0) begin
                        done_q  <= 1'b1;
                        stall_q <= 1'b0;
                        if (op_q == OP_READ) begin
                            read_data_q <= rd_word;
                        end
                        state <= (halt_pend || bus.halt) ? ST_HALTED : ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HALTED: begin
                    stall_q <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.readData = read_data_q;
    assign bus.done     = done_q;
    assign bus.stall    = stall_q;
    assign bus.err      = err_q;

endmodule
